// File: rtl/mul_unit.sv
// RV32M multiply unit: MUL/MULH/MULHSU/MULHU over an unsigned 32x32 array.
// Three-cycle sequence: accept, multiply, sign-fix and word select.
module mul_unit (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        kill_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned PLEN = 2 * XLEN;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_FIX  = 2'b10
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   b_q;
   logic [PLEN-1:0]   p_q;
   logic              neg_q;
   logic [1:0]        op_q;

   logic              sa;
   logic              sb;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic [PLEN-1:0]   prod;
   logic [PLEN-1:0]   fixed;

   // Unsigned 32x32 array product.
   function automatic logic [PLEN-1:0] multiplier_32(input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
      return PLEN'(a) * PLEN'(b);
   endfunction

   // Operand signedness and magnitudes; |0x80000000| stays 0x80000000.
   always_comb begin
      sa    = (op_i == OP_MULH) || (op_i == OP_MULHSU);
      sb    = (op_i == OP_MULH);
      a_neg = sa & rs1_i[XLEN-1];
      b_neg = sb & rs2_i[XLEN-1];
      a_mag = a_neg ? (~rs1_i + XLEN'(1)) : rs1_i;
      b_mag = b_neg ? (~rs2_i + XLEN'(1)) : rs2_i;
      prod  = multiplier_32(a_q, b_q);
      fixed = neg_q ? (~p_q + PLEN'(1)) : p_q;
   end

   assign busy_o = (state == ST_MUL) || (state == ST_FIX);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state    <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         p_q      <= '0;
         neg_q    <= 1'b0;
         op_q     <= '0;
         done_o   <= 1'b0;
         result_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i && !kill_i) begin
                  a_q   <= a_mag;
                  b_q   <= b_mag;
                  neg_q <= a_neg ^ b_neg;
                  op_q  <= op_i;
                  state <= ST_MUL;
               end
            end
            ST_MUL: begin
               if (kill_i) begin
                  state <= ST_IDLE;
               end else begin
                  p_q   <= prod;
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (!kill_i) begin
                  result_o <= (op_q == OP_MUL) ? fixed[XLEN-1:0] : fixed[PLEN-1:XLEN];
                  done_o   <= 1'b1;
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Directed and table-driven checks for mul_unit against hand-computed values.
`timescale 1ns/1ps
module tb_mul_unit;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        kill;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   mul_unit dut (
      .clk_i   (clk),
      .reset_i (reset_n),
      .start_i (start),
      .op_i    (op),
      .rs1_i   (rs1),
      .rs2_i   (rs2),
      .kill_i  (kill),
      .busy_o  (busy),
      .done_o  (done),
      .result_o(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Independent reference: sign/zero extend to 64 bits and multiply modulo 2^64.
   function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Issue one op and check busy/done timing and the result.
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      @(negedge clk);
      start = 1'b1; op = o; rs1 = a; rs2 = b;
      @(negedge clk);
      start = 1'b0;
      chk({name, " busy c1"}, 32'(busy), 32'd1);
      chk({name, " done c1"}, 32'(done), 32'd0);
      @(negedge clk);
      chk({name, " busy c2"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({name, " done c3"}, 32'(done), 32'd1);
      chk({name, " busy c3"}, 32'(busy), 32'd0);
      chk({name, " result"}, result, exp);
   endtask

   initial begin
      int done_cnt;
      logic [31:0] held;
      logic [1:0]  bo[4];
      logic [31:0] ba[4];
      logic [31:0] bb[4];

      vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
      vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[5]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
      vecs[6]  = '{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
      vecs[7]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[8]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[9]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
      vecs[10] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};

      reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0;
      #12;
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Back-to-back: restart in each done cycle.
      for (int k = 0; k < 4; k++) begin
         bo[k] = 2'($urandom_range(0, 3));
         ba[k] = $urandom;
         bb[k] = $urandom;
      end
      @(negedge clk);
      start = 1'b1; op = bo[0]; rs1 = ba[0]; rs2 = bb[0];
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("b2b%0d done c1", k), 32'(done), 32'd0);
         @(negedge clk);
         chk($sformatf("b2b%0d done c2", k), 32'(done), 32'd0);
         @(negedge clk);
         chk($sformatf("b2b%0d done c3", k), 32'(done), 32'd1);
         chk($sformatf("b2b%0d result", k), result, ref_mul(bo[k], ba[k], bb[k]));
         if (k < 3) begin
            op = bo[k+1]; rs1 = ba[k+1]; rs2 = bb[k+1];
         end else begin
            start = 1'b0;
         end
      end

      // Start pulsed while busy is ignored.
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs1 = 32'd6; rs2 = 32'd7;
      @(negedge clk);
      op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      chk("ignore start done count", 32'(done_cnt), 32'd1);
      chk("ignore start result", result, 32'd42);

      // Kill in MUL.
      held = result;
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
      @(negedge clk);
      start = 1'b0; kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill mul busy", 32'(busy), 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      chk("kill mul done count", 32'(done_cnt), 32'd0);
      chk("kill mul result", result, held);

      // Kill in FIX.
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd9;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill fix busy", 32'(busy), 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      chk("kill fix done count", 32'(done_cnt), 32'd0);
      chk("kill fix result", result, held);

      // Kill together with start in IDLE drops the start.
      @(negedge clk);
      start = 1'b1; kill = 1'b1; op = 2'b00; rs1 = 32'd2; rs2 = 32'd2;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("kill idle busy", 32'(busy), 32'd0);

      // Async reset in FIX clears outputs immediately.
      run_op("pre reset", 2'b00, 32'd11, 32'd13, 32'd143);
      @(negedge clk);
      start = 1'b1; op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("reset fix result", result, 32'd0);
      chk("reset fix done", 32'(done), 32'd0);
      chk("reset fix busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_op("post reset", 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_unit.md
# mul_unit

Sequential RV32M multiply unit that wraps the unsigned 32x32 `multiplier_32` array and handles operand signedness, product registering and upper/lower word selection for MUL, MULH, MULHSU and MULHU. It sits between the execute-stage operand/issue logic and the `multiplier_32` instance. It presents a start/busy/done handshake to the core pipeline and returns one 32-bit result per accepted operation.

## Interface
- No parameters; width fixed at 32 (XLEN).

- `clk_i` input 1: single clock, all state on rising edge.
- `reset_i` input 1: asynchronous, active-low reset.
- `start_i` input 1: request; accepted only in IDLE.
- `op_i` input 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; sampled on accept.
- `rs1_i` input 32: multiplicand; sampled on accept.
- `rs2_i` input 32: multiplier; sampled on accept.
- `kill_i` input 1: synchronous abort of an in-flight operation (pipeline flush).
- `busy_o` output 1: high in MUL and FIX states; combinational from state.
- `done_o` output 1: registered, one-cycle pulse; `result_o` valid while high.
- `result_o` output 32: registered result; holds its last value until the next completion.

## Operation
- Reset is asynchronous and active-low. While `reset_i`=0:
  - state=IDLE, `done_o`=0, `result_o`=0.
  - All internal operand, product and flag registers are 0.
- Signedness per op:
  - MUL: result is the same either way, so both operands are treated as unsigned.
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both operands unsigned.
- Accept (IDLE and `start_i`=1):
  - `a_q` = |rs1| if rs1 is treated as signed and rs1[31]=1, else rs1. Same rule for `b_q` from rs2.
  - |0x80000000| = 0x80000000, which is a valid unsigned value.
  - `neg_q` = (sa & rs1[31]) ^ (sb & rs2[31]), where sa/sb are the signed flags for the op.
  - `op_q` = `op_i`.
  - Next state is MUL.
- MUL state: `p_q` (64b) <= `multiplier_32`(`a_q`, `b_q`). Next state is FIX.
- FIX state:
  - `f` = `neg_q` ? (~`p_q` + 1) : `p_q`, computed at full 64-bit width, modulo 2^64.
  - `result_o` <= `f`[31:0] for MUL, else `f`[63:32].
  - `done_o` <= 1. Next state is IDLE.
- `done_o` returns to 0 on the following edge unless a new completion occurs.
- `start_i` while not in IDLE is ignored. No queuing; the requester holds `start_i` until it sees `busy_o`.
- `kill_i`=1 in MUL or FIX:
  - Next state is IDLE and no `done_o` is generated.
  - `result_o` is unchanged.
- `kill_i`=1 in IDLE together with `start_i`: the start is dropped (kill has priority).
- Zero product with `neg_q`=1 yields 0 (two's complement of zero). No special case.

## Timing
- FSM states: IDLE -> MUL -> FIX -> IDLE. There are no other states; an illegal encoding recovers to IDLE.
- Latency: accept on edge E0; `p_q` loads on E1; `result_o`/`done_o` load on E2.
- `done_o` is high for the cycle after E2, three cycles after the start cycle.
- Throughput: one operation per 3 cycles.
  - A new `start_i` is accepted in the cycle `done_o` is high, because the state is already IDLE.
  - Back-to-back issue gives a `done_o` every 3 cycles.
- `busy_o` is high exactly in the two cycles following an accept (MUL and FIX states). It is low in the `done_o` cycle.
- The combinational path is one `multiplier_32` evaluation, from the `a_q`/`b_q` registers to `p_q`. The 64-bit negate sits in the FIX cycle only.
- Asynchronous reset mid-operation:
  - Immediately forces IDLE, `done_o`=0 and `result_o`=0.
  - The first accept after reset release completes normally.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (−3) -> `done_o` 3 cycles after start, `result_o`=0xFFFFFFEB.
- MULH, 0x80000000 × 0x80000000 -> `result_o`=0x40000000. MULH, 0xFFFFFFFF × 0x00000000 -> 0x00000000.
- MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> `result_o`=0xFFFFFFFF. MULHU on the same operands -> 0xFFFFFFFE.
- Back-to-back: start asserted again in each `done_o` cycle for 4 random ops.
  - Required: `done_o` pulses every 3 cycles.
  - Results match a 64-bit signed/unsigned reference model.
- `start_i` pulsed while `busy_o`=1 -> ignored; exactly one `done_o` and the original result.
- `kill_i` in MUL (and separately in FIX) -> no `done_o`, `result_o` unchanged, `busy_o` low next cycle.
- `reset_i` low in FIX -> `done_o`=0 and `result_o`=0 immediately; the next op after release completes correctly.
